// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the register hazard scoreboard.
//   fsm_state_t  : drain sequencer encoding (IDLE / DRAIN / DONE)
//   NUM_REGS     : architectural register count
//   REG_IDX_W    : width of a register index
//   reg_onehot() : one-hot decode of a register index
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        DONE  = 2'b10
    } fsm_state_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_popcount32.sv
// ---------------------------------------------------------------------------
// popcount32
// Counts the set bits of a 32-bit vector (purely combinational).
//   bits  : in  32  vector to count
//   count : out 6   number of ones, 0..32
// ---------------------------------------------------------------------------
module popcount32
    import hazard_scoreboard_pkg::*;
(
    input  logic [NUM_REGS-1:0] bits,
    output logic [5:0]          count
);

    always_comb begin
        count = 6'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count = count + 6'(bits[i]);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Tracks registers with an outstanding write and stalls decode on RAW/WAW
// hazards. A small sequencer drains the pipeline on request and pulses
// drain_done once nothing is pending.
//
// Ports
//   clock          in  1   sole clock, rising edge
//   reset          in  1   synchronous, active-high
//   issue_valid    in  1   decode holds an instruction
//   issue_reg_S1   in  5   source register 1
//   issue_reg_S2   in  5   source register 2
//   issue_reg_D    in  5   destination register
//   issue_writes   in  1   instruction writes issue_reg_D
//   wb_valid       in  1   writeback retiring this cycle
//   wb_reg         in  5   register being retired
//   drain_req      in  1   one-cycle drain request
//   flush          in  1   discard all pending writes
//   stall          out 1   decode must hold
//   issue_fire     out 1   issue accepted this cycle
//   pending_count  out 6   registered count of pending registers
//   drain_done     out 1   one-cycle drain completion pulse
//
// Build option
//   SCOREBOARD_WB_BYPASS_EN : when defined, a register retiring this cycle
//   no longer causes a stall, so a dependent instruction issues in the same
//   cycle as its producer's writeback.
//
// Drain sequencer
//   state | meaning
//   IDLE  | normal issue, waiting for drain_req
//   DRAIN | issue blocked, waiting for pending vector to empty
//   DONE  | drain complete, drain_done high for this one cycle
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_reg_S1,
    input  logic [REG_IDX_W-1:0] issue_reg_S2,
    input  logic [REG_IDX_W-1:0] issue_reg_D,
    input  logic                 issue_writes,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic                 drain_req,
    input  logic                 flush,
    output logic                 stall,
    output logic                 issue_fire,
    output logic [5:0]           pending_count,
    output logic                 drain_done
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] hazard_vec;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [5:0]          count_d;
    logic                hazard;
    logic                pending_empty;

    fsm_state_t state_q;
    fsm_state_t state_d;

    assign clr_vec = wb_valid ? reg_onehot(wb_reg) : '0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The retiring register is treated as already written back.
    assign hazard_vec = pending_q & ~clr_vec;
`else
    assign hazard_vec = pending_q;
`endif

    assign hazard = issue_valid &
                    (hazard_vec[issue_reg_S1] |
                     hazard_vec[issue_reg_S2] |
                     (issue_writes & hazard_vec[issue_reg_D]));

    assign stall      = hazard | (state_q != IDLE);
    assign issue_fire = issue_valid & ~stall;

    assign set_vec = (issue_fire && issue_writes && (issue_reg_D != '0)) ?
                     reg_onehot(issue_reg_D) : '0;

    // Set is applied after clear so a same-register set/clear (only
    // reachable with bypass) leaves the bit pending. Flush overrides both.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    assign pending_empty = (pending_q == '0);

    popcount32 u_popcount (
        .bits  (pending_d),
        .count (count_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q     <= '0;
            pending_count <= 6'd0;
        end else begin
            pending_q     <= pending_d;
            pending_count <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = pending_empty ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (pending_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                drain_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_reg_S1;
    logic [4:0] issue_reg_S2;
    logic [4:0] issue_reg_D;
    logic       issue_writes;
    logic       wb_valid;
    logic [4:0] wb_reg;
    logic       drain_req;
    logic       flush;
    logic       stall;
    logic       issue_fire;
    logic [5:0] pending_count;
    logic       drain_done;

    hazard_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_reg_S1  (issue_reg_S1),
        .issue_reg_S2  (issue_reg_S2),
        .issue_reg_D   (issue_reg_D),
        .issue_writes  (issue_writes),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .drain_req     (drain_req),
        .flush         (flush),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .pending_count (pending_count),
        .drain_done    (drain_done)
    );

    always #5 clock = ~clock;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: set of registers awaiting writeback, and where the
    // drain request currently stands.
    bit [31:0] m_pend;
    bit        m_draining;   // drain requested, still waiting for empty
    bit        m_done_now;   // this cycle is the completion cycle

    logic       obs_stall, obs_fire, obs_done;
    logic [5:0] obs_count;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_blocks(input logic [4:0] r);
        if (!m_pend[r]) return 1'b0;
        if (BYPASS && wb_valid && wb_reg == r) return 1'b0;
        return 1'b1;
    endfunction

    // Drives one cycle of inputs (called #1 after a rising edge), checks the
    // combinational outputs, advances the model across the edge, then checks
    // the registered outputs.
    task automatic step(input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic w, input logic wbv,
                        input logic [4:0] wbr, input logic dr, input logic fl,
                        input logic rst);
        bit        e_stall, e_fire, old_empty;
        bit [31:0] nxt;
        issue_valid = iv;  issue_reg_S1 = s1; issue_reg_S2 = s2;
        issue_reg_D = d;   issue_writes = w;  wb_valid = wbv;
        wb_reg = wbr;      drain_req = dr;    flush = fl; reset = rst;
        #1;
        e_stall = (iv && (m_blocks(s1) || m_blocks(s2) || (w && m_blocks(d))))
                  || m_draining || m_done_now;
        e_fire  = iv && !e_stall;
        obs_stall = stall;
        obs_fire  = issue_fire;
        if (!rst) begin
            chk("stall", int'(stall), int'(e_stall));
            chk("issue_fire", int'(issue_fire), int'(e_fire));
        end
        old_empty = (m_pend == 0);
        nxt = m_pend;
        if (wbv) nxt[wbr] = 1'b0;
        if (e_fire && w && d != 0) nxt[d] = 1'b1;
        if (fl) nxt = 0;
        nxt[0] = 1'b0;
        if (rst) begin
            m_pend = 0; m_draining = 0; m_done_now = 0;
        end else begin
            m_pend = nxt;
            if (m_done_now) begin
                m_done_now = 0;
            end else if (m_draining) begin
                if (old_empty) begin m_draining = 0; m_done_now = 1; end
            end else if (dr) begin
                if (old_empty) m_done_now = 1;
                else           m_draining = 1;
            end
        end
        @(posedge clock);
        #1;
        obs_count = pending_count;
        obs_done  = drain_done;
        chk("pending_count", int'(pending_count), $countones(m_pend));
        chk("drain_done", int'(drain_done), int'(m_done_now));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        m_pend = 0; m_draining = 0; m_done_now = 0;
        reset = 1; issue_valid = 0; issue_reg_S1 = 0; issue_reg_S2 = 0;
        issue_reg_D = 0; issue_writes = 0; wb_valid = 0; wb_reg = 0;
        drain_req = 0; flush = 0;
        @(posedge clock); #1;
        do_reset();
        chk("reset_count", int'(obs_count), 0);
        chk("reset_done", int'(obs_done), 0);
        idle();
        chk("reset_stall", int'(obs_stall), 0);

        // r0 is never pending
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("r0_write_count", int'(obs_count), 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_read_stall", int'(obs_stall), 0);
        chk("r0_read_count", int'(obs_count), 0);

        // RAW on r5 resolved by writeback
        step(1, 1, 2, 5, 1, 0, 0, 0, 0, 0);
        chk("r5_issue_fire", int'(obs_fire), 1);
        chk("r5_count", int'(obs_count), 1);
        step(1, 5, 0, 6, 0, 0, 0, 0, 0, 0);
        chk("raw_stall", int'(obs_stall), 1);
        step(1, 5, 0, 6, 0, 1, 5, 0, 0, 0);
        chk("raw_wb_fire", int'(obs_fire), BYPASS ? 1 : 0);
        chk("raw_wb_count", int'(obs_count), 0);
        if (!BYPASS) begin
            step(1, 5, 0, 6, 0, 0, 0, 0, 0, 0);
            chk("raw_after_wb_fire", int'(obs_fire), 1);
        end

        // Drain with r3, r7 pending
        step(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("drain_pre_count", int'(obs_count), 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0, 1, 3, 0, 0, 0);
        chk("drain_stall_a", int'(obs_stall), 1);
        step(1, 1, 1, 0, 0, 1, 7, 0, 0, 0);
        chk("drain_stall_b", int'(obs_stall), 1);
        chk("drain_empty_done", int'(obs_done), 0);
        idle();
        chk("drain_done_pulse", int'(obs_done), 1);
        idle();
        chk("drain_done_once", int'(obs_done), 0);
        step(1, 3, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("drain_back_idle", int'(obs_fire), 1);

        // Flush overrides same-cycle writeback
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("flush_pre_count", int'(obs_count), 3);
        step(0, 0, 0, 0, 0, 1, 2, 0, 1, 0);
        chk("flush_count", int'(obs_count), 0);
        step(1, 1, 2, 4, 1, 0, 0, 0, 0, 0);
        chk("flush_no_stall", int'(obs_stall), 0);
        do_reset();

        // Reset in the middle of a drain
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("rst_drain_count", int'(obs_count), 0);
        chk("rst_drain_done", int'(obs_done), 0);
        idle();
        chk("rst_drain_done_later", int'(obs_done), 0);
        chk("rst_drain_stall", int'(obs_stall), 0);

        // Drain with nothing pending, second request during DONE ignored
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("empty_drain_done", int'(obs_done), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("empty_drain_again", int'(obs_done), 0);
        idle();
        chk("empty_drain_idle", int'(obs_done), 0);

        // Randomized traffic over a small register window to force hazards
        for (int n = 0; n < 3000; n++) begin
            logic       iv, w, wbv, dr, fl, rst;
            logic [4:0] s1, s2, d, wbr;
            iv  = ($urandom_range(0, 99) < 65);
            s1  = 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            d   = 5'($urandom_range(0, 7));
            w   = ($urandom_range(0, 99) < 70);
            wbv = ($urandom_range(0, 99) < 45);
            wbr = 5'($urandom_range(0, 7));
            dr  = ($urandom_range(0, 99) < 4);
            fl  = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 999) < 3);
            step(iv, s1, s2, d, w, wbv, wbr, dr, fl, rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: issue_valid  in  1  decode holds an instruction to issue.
REQ-004 SHALL have ports: issue_reg_S1, issue_reg_S2  in  5 each  source registers from decode.
REQ-005 SHALL have ports: issue_reg_D  in  5  destination register; issue_writes  in  1  instruction writes reg_D.
REQ-006 SHALL have ports: wb_valid  in  1  writeback retiring; wb_reg  in  5  register retired.
REQ-007 SHALL have ports: drain_req  in  1  one-cycle pulse requesting pipeline drain.
REQ-008 SHALL have ports: flush  in  1  discard all pending writes.
REQ-009 SHALL have ports: stall  out  1  decode must hold; issue_fire  out  1  issue accepted this cycle.
REQ-010 SHALL have ports: pending_count  out  6  number of pending registers; drain_done  out  1  one-cycle pulse.

Function
REQ-011 SHALL keep a 32-bit pending vector; bit 0 never set (r0 hardwired).
REQ-012 SHALL assert stall combinationally when issue_valid and (pending[S1] or pending[S2] or (issue_writes and pending[D])), or when FSM is not IDLE.
REQ-013 SHALL drive issue_fire = issue_valid & ~stall.
REQ-014 SHALL set pending[D] on the rising edge after issue_fire & issue_writes & D != 0.
REQ-015 SHALL clear pending[wb_reg] on the rising edge after wb_valid; wb_reg = 0 or an already-clear bit is a no-op.
REQ-016 SHALL, on simultaneous set and clear of different registers, apply both; same register cannot occur without bypass (WAW stall); with bypass, set wins.
REQ-017 SHALL clear all pending bits on flush, overriding same-cycle set and clear; stall evaluated that cycle uses pre-flush state.
REQ-018 SHALL drive pending_count as registered popcount of the next pending vector (0..31), valid one cycle after the update.
REQ-019 SHALL implement FSM IDLE -> DRAIN on drain_req; DRAIN -> DONE when the pending vector is all zero; DONE -> IDLE unconditionally.
REQ-020 SHALL pass IDLE -> DONE directly when drain_req arrives with nothing pending.
REQ-021 SHALL assert drain_done only in DONE, exactly one cycle; drain_req outside IDLE is ignored.
REQ-022 SHALL move DRAIN -> DONE on the cycle after flush, since flush empties the vector.

Reset
REQ-023 SHALL, on reset, clear pending, set pending_count=0, FSM=IDLE, drain_done=0; stall then follows REQ-012 with empty state.
REQ-024 SHALL give reset priority over flush, drain_req, issue and writeback; reset mid-drain returns to IDLE with no drain_done.

Configuration
REQ-025 SHALL support macro SCOREBOARD_WB_BYPASS_EN.
REQ-026 SHALL, when it is defined, mask pending[wb_reg] from the stall terms in the same cycle wb_valid is high, so a dependent instruction issues the same cycle as writeback.
REQ-027 SHALL, when it is undefined, compute stall from registered pending only, so a dependent instruction issues one cycle after writeback.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=2'b00, DRAIN=2'b01, DONE=2'b10), NUM_REGS=32 and REG_IDX_W=5 in a shared package.
REQ-029 SHALL use one sub-module, popcount32, for pending_count; everything else stays flat.

Verification
REQ-030 Issue D=5 writes; next cycle issue S1=5: stall=1 until wb_reg=5; issue_fire follows per bypass setting (same cycle if SCOREBOARD_WB_BYPASS_EN, else next).
REQ-031 Issue D=0 writes, then S1=0: no stall, pending_count stays 0.
REQ-032 Pend r3, r7; drain_req: stall=1 throughout; wb r3, wb r7; drain_done pulses one cycle after the vector empties; FSM returns to IDLE.
REQ-033 Pend r1, r2, r4 (pending_count=3); flush with wb_reg=2 the same cycle: next cycle count=0 and no stall on any register.
REQ-034 Pend r9; drain_req; reset asserted in DRAIN: all cleared, drain_done never pulses.
REQ-035 drain_req with pending empty: drain_done pulses on the next cycle; back-to-back drain_req during DONE is ignored.
